// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the platform-jumper.
// Sequences TITLE -> SPAWN -> PLAY <-> PAUSE -> DYING -> SPAWN/OVER, drives the
// ball's reset/enable, detects falls below the floor and keeps score, lives
// and the high score.
module game_sequencer #(
   parameter int          LIVES        = 3,
   parameter int          SPAWN_FRAMES = 8,
   parameter int          DEATH_FRAMES = 60,
   parameter logic [10:0] DEATH_Y      = 11'd470,
   parameter logic [7:0]  KEY_START    = 8'd44,
   parameter logic [7:0]  KEY_PAUSE    = 8'd19
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [7:0]  keycode,
   input  logic [10:0] BallY,
   input  logic [15:0] jump_count,
   output logic        ball_reset,
   output logic        play_en,
   output logic [2:0]  state,
   output logic [15:0] score,
   output logic [15:0] high_score,
   output logic [1:0]  lives,
   output logic        game_over
);

   typedef enum logic [2:0] {
      TITLE = 3'd0,
      SPAWN = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      DYING = 3'd4,
      OVER  = 3'd5
   } phase_t;

   localparam logic [7:0] SPAWN_LAST = 8'(SPAWN_FRAMES - 1);
   localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   phase_t      cur;
   logic [7:0]  frame_cnt;
   logic [7:0]  key_prev;
   logic [15:0] base;
   logic [15:0] acc;
   logic [16:0] sum;
   logic [15:0] play_score;
   logic        start_press;
   logic        pause_press;

   // Moore output pattern {ball_reset, play_en, game_over} for a phase; the
   // outputs are loaded together with the phase so they switch on the same edge.
   function automatic logic [2:0] moore(input phase_t p);
      case (p)
         TITLE:   moore = 3'b100;
         SPAWN:   moore = 3'b100;
         PLAY:    moore = 3'b010;
         PAUSE:   moore = 3'b000;
         DYING:   moore = 3'b000;
         OVER:    moore = 3'b101;
         default: moore = 3'b100;
      endcase
   endfunction

   assign state       = cur;
   assign start_press = (keycode == KEY_START) && (key_prev != KEY_START);
   assign pause_press = (keycode == KEY_PAUSE) && (key_prev != KEY_PAUSE);

   // Running score: banked score plus jumps since spawn, saturating at 16'hFFFF.
   always_comb begin
      sum        = {1'b0, acc} + {1'b0, 16'(jump_count - base)};
      play_score = sum[16] ? '1 : sum[15:0];
   end

   assign score = (cur == PLAY) ? play_score : acc;

   // Game-flow state machine with frame counter, key edge tracking and bookkeeping.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         cur        <= TITLE;
         ball_reset <= 1'b1;
         play_en    <= 1'b0;
         game_over  <= 1'b0;
         frame_cnt  <= '0;
         key_prev   <= '0;
         base       <= '0;
         acc        <= '0;
         lives      <= '0;
         high_score <= '0;
      end else begin
         key_prev  <= keycode;
         frame_cnt <= frame_cnt + 8'd1;
         case (cur)
            TITLE: begin
               if (start_press) begin
                  lives     <= LIVES_INIT;
                  acc       <= '0;
                  cur       <= SPAWN;
                  frame_cnt <= '0;
                  {ball_reset, play_en, game_over} <= moore(SPAWN);
               end
            end
            SPAWN: begin
               if (frame_cnt == SPAWN_LAST) begin
                  base      <= jump_count;
                  cur       <= PLAY;
                  frame_cnt <= '0;
                  {ball_reset, play_en, game_over} <= moore(PLAY);
               end
            end
            PLAY: begin
               // A fall wins over a pause press arriving on the same frame.
               if (BallY >= DEATH_Y) begin
                  acc <= play_score;
                  if (lives != '0)
                     lives <= lives - 2'd1;
                  cur       <= DYING;
                  frame_cnt <= '0;
                  {ball_reset, play_en, game_over} <= moore(DYING);
               end else if (pause_press) begin
                  cur       <= PAUSE;
                  frame_cnt <= '0;
                  {ball_reset, play_en, game_over} <= moore(PAUSE);
               end
            end
            PAUSE: begin
               if (pause_press) begin
                  cur       <= PLAY;
                  frame_cnt <= '0;
                  {ball_reset, play_en, game_over} <= moore(PLAY);
               end
            end
            DYING: begin
               if (frame_cnt == DEATH_LAST) begin
                  frame_cnt <= '0;
                  if (lives == '0) begin
                     if (acc > high_score)
                        high_score <= acc;
                     cur <= OVER;
                     {ball_reset, play_en, game_over} <= moore(OVER);
                  end else begin
                     cur <= SPAWN;
                     {ball_reset, play_en, game_over} <= moore(SPAWN);
                  end
               end
            end
            OVER: begin
               if (start_press) begin
                  cur       <= TITLE;
                  frame_cnt <= '0;
                  {ball_reset, play_en, game_over} <= moore(TITLE);
               end
            end
            default: begin
               cur       <= TITLE;
               frame_cnt <= '0;
               {ball_reset, play_en, game_over} <= moore(TITLE);
            end
         endcase
      end
   end

endmodule
